// File: rtl/pipe_trace_tagger.sv
// rtl/pipe_trace_tagger.sv - shadow trace tagger tracking instructions through the five-stage pipeline
module pipe_trace_tagger #(
  parameter int ID_W  = 8,
  parameter int CYC_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_id_stall,
  input  logic              if_flush,
  input  logic [15:0]       fetch_pc,
  input  logic [15:0]       fetch_instr,
  output logic [ID_W-1:0]   if_id_tag,
  output logic [ID_W-1:0]   id_ex_tag,
  output logic [ID_W-1:0]   ex_mem_tag,
  output logic [ID_W-1:0]   mem_wb_tag,
  output logic              retire_valid,
  output logic [ID_W-1:0]   retire_id,
  output logic [15:0]       retire_pc,
  output logic [15:0]       retire_instr,
  output logic              retire_flushed,
  output logic [CYC_W-1:0]  retire_cycle,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [CYC_W-1:0]  retired_count,
  output logic [CYC_W-1:0]  flushed_count,
  output logic              done
);

  typedef struct packed {
    logic            valid;
    logic            flushed;
    logic [ID_W-1:0] id;
    logic [15:0]     pc;
    logic [15:0]     instr;
  } slot_t;

  slot_t            if_id_q, if_id_d;
  slot_t            id_ex_q, id_ex_d;
  slot_t            ex_mem_q, ex_mem_d;
  slot_t            mem_wb_q, mem_wb_d;
  logic [ID_W-1:0]  next_id_q, next_id_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [CYC_W-1:0] retired_q, retired_d;
  logic [CYC_W-1:0] flushed_q, flushed_d;
  logic             done_q, done_d;

  // Slot shifting: stall holds IF/ID and drops a bubble into ID/EX; later stages always advance
  always_comb begin
    if_id_d   = if_id_q;
    next_id_d = next_id_q;
    if (!if_id_stall) begin
      if_id_d.valid   = 1'b1;
      if_id_d.flushed = if_flush;
      if_id_d.id      = next_id_q;
      if_id_d.pc      = fetch_pc;
      if_id_d.instr   = fetch_instr;
      if (!done_q) begin
        next_id_d = next_id_q + 1'b1;
      end
    end
    id_ex_d  = if_id_stall ? '0 : if_id_q;
    ex_mem_d = id_ex_q;
    mem_wb_d = ex_mem_q;
  end

  // Retire view of the MEM/WB slot; everything reads zero once halted or on a bubble
  always_comb begin
    retire_valid   = mem_wb_q.valid & ~done_q;
    retire_id      = retire_valid ? mem_wb_q.id      : '0;
    retire_pc      = retire_valid ? mem_wb_q.pc      : '0;
    retire_instr   = retire_valid ? mem_wb_q.instr   : '0;
    retire_flushed = retire_valid ? mem_wb_q.flushed : 1'b0;
    retire_cycle   = retire_valid ? cycle_q          : '0;
  end

  // Saturating counters and the sticky halt flag, all frozen after halt
  always_comb begin
    cycle_d   = cycle_q;
    retired_d = retired_q;
    flushed_d = flushed_q;
    done_d    = done_q;
    if (!done_q && cycle_q != {CYC_W{1'b1}}) begin
      cycle_d = cycle_q + 1'b1;
    end
    if (retire_valid && !retire_flushed && retired_q != {CYC_W{1'b1}}) begin
      retired_d = retired_q + 1'b1;
    end
    if (retire_valid && retire_flushed && flushed_q != {CYC_W{1'b1}}) begin
      flushed_d = flushed_q + 1'b1;
    end
    if (retire_valid && !retire_flushed && retire_instr[15:12] == 4'hF) begin
      done_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q   <= '0;
      id_ex_q   <= '0;
      ex_mem_q  <= '0;
      mem_wb_q  <= '0;
      next_id_q <= '0;
      cycle_q   <= '0;
      retired_q <= '0;
      flushed_q <= '0;
      done_q    <= 1'b0;
    end else begin
      if_id_q   <= if_id_d;
      id_ex_q   <= id_ex_d;
      ex_mem_q  <= ex_mem_d;
      mem_wb_q  <= mem_wb_d;
      next_id_q <= next_id_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
      flushed_q <= flushed_d;
      done_q    <= done_d;
    end
  end

  // Per-slot tags; bubbles read as zero
  always_comb begin
    if_id_tag  = if_id_q.valid  ? if_id_q.id  : '0;
    id_ex_tag  = id_ex_q.valid  ? id_ex_q.id  : '0;
    ex_mem_tag = ex_mem_q.valid ? ex_mem_q.id : '0;
    mem_wb_tag = mem_wb_q.valid ? mem_wb_q.id : '0;
  end

  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;
  assign flushed_count = flushed_q;
  assign done          = done_q;

endmodule
